// File: rtl/gbc_gamepak_sequencer.sv
// gbc_gamepak_sequencer: GBC cartridge-port bus cycle sequencer shared by CPU (rd/wr) and HDMA/GDMA (rd).
// Every granted transaction runs SETUP, STROBE and HOLD phases of CLK_DIV clocks each.
// After reset, PakReset is held for RST_HOLD clocks before any request is accepted.
// Ports:
//   Clk, Reset                         system clock, async active-high reset
//   CpuReq/CpuWe/CpuAddr/CpuWData      CPU request, held until CpuAck
//   CpuAck/CpuRData                    CPU completion pulse and read data
//   DmaReq/DmaAddr                     DMA read request, held until DmaAck
//   DmaAck/DmaRData                    DMA completion pulse and read data
//   PakClk/PakRead/PakWrite/PakCS      cartridge strobes
//   PakAddr/PakDOut/PakDOE/PakDIn      cartridge address and data
//   PakReset                           cartridge reset
// Build option: define GBC_PAK_RR_ARB_EN for round-robin arbitration (default is fixed CPU priority).
module gbc_gamepak_sequencer #(
  parameter int CLK_DIV  = 4,
  parameter int RST_HOLD = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CpuReq,
  input  logic        CpuWe,
  input  logic [15:0] CpuAddr,
  input  logic [7:0]  CpuWData,
  output logic        CpuAck,
  output logic [7:0]  CpuRData,
  input  logic        DmaReq,
  input  logic [15:0] DmaAddr,
  output logic        DmaAck,
  output logic [7:0]  DmaRData,
  output logic        PakClk,
  output logic        PakRead,
  output logic        PakWrite,
  output logic        PakCS,
  output logic [15:0] PakAddr,
  output logic [7:0]  PakDOut,
  output logic        PakDOE,
  input  logic [7:0]  PakDIn,
  output logic        PakReset
);
  localparam int CMAX = CLK_DIV > RST_HOLD ? CLK_DIV : RST_HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d, rdata_q, rdata_d;
  logic          we_q, we_d, dma_q, dma_d;
  logic          cpu_first, grant_cpu, take, phase_end, rst_end, busy;
`ifdef GBC_PAK_RR_ARB_EN
  // Last owner: 1 = DMA, so the CPU wins the first tie after reset.
  logic last_dma_q;
  assign cpu_first = last_dma_q;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) last_dma_q <= 1'b1;
    else if (take) last_dma_q <= !grant_cpu;
`else
  assign cpu_first = 1'b1;
`endif
  assign grant_cpu = CpuReq & (cpu_first | !DmaReq);
  assign take      = (state_q == S_IDLE) & (CpuReq | DmaReq);
  assign phase_end = cnt_q == CW'(CLK_DIV - 1);
  assign rst_end   = cnt_q == CW'(RST_HOLD - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = rst_end ? S_IDLE : S_RST;
      S_IDLE:   state_d = take ? S_SETUP : S_IDLE;
      S_SETUP:  state_d = phase_end ? S_STROBE : S_SETUP;
      S_STROBE: state_d = phase_end ? S_HOLD : S_STROBE;
      S_HOLD:   state_d = phase_end ? S_IDLE : S_HOLD;
      default:  state_d = S_RST;
    endcase
  end
  // Phase counter restarts on every state change and rests at zero in IDLE.
  assign cnt_d   = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
  assign addr_d  = take ? (grant_cpu ? CpuAddr : DmaAddr) : addr_q;
  assign we_d    = take ? grant_cpu & CpuWe : we_q;
  assign wdata_d = (take & grant_cpu) ? CpuWData : wdata_q;
  assign dma_d   = take ? !grant_cpu : dma_q;
  // Read data is captured on the last STROBE edge and held until the next read capture.
  assign rdata_d = (state_q == S_STROBE && phase_end && !we_q) ? PakDIn : rdata_q;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      dma_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      dma_q   <= dma_d;
    end
  assign busy     = state_q == S_SETUP || state_q == S_STROBE || state_q == S_HOLD;
  assign PakReset = state_q == S_RST;
  assign PakClk   = state_q == S_STROBE;
  assign PakWrite = PakClk & we_q;
  assign PakRead  = busy & !we_q;
  assign PakDOE   = busy & we_q;
  assign PakCS    = busy & (addr_q[15:13] == 3'b101);
  assign PakAddr  = addr_q;
  assign PakDOut  = wdata_q;
  assign CpuAck   = (state_q == S_HOLD) & phase_end & !dma_q;
  assign DmaAck   = (state_q == S_HOLD) & phase_end & dma_q;
  assign CpuRData = rdata_q;
  assign DmaRData = rdata_q;
endmodule

// File: tb/tb_gbc_gamepak_sequencer.sv
// tb_gbc_gamepak_sequencer: directed and randomized checks of the GamePak sequencer against a cycle-index model.
module tb_gbc_gamepak_sequencer;
  localparam int D = 4;
  localparam int H = 16;
`ifdef GBC_PAK_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        Clk = 1'b0, Reset = 1'b0;
  logic        CpuReq = 1'b0, CpuWe = 1'b0, DmaReq = 1'b0;
  logic [15:0] CpuAddr = '0, DmaAddr = '0;
  logic [7:0]  CpuWData = '0, PakDIn = '0;
  logic        CpuAck, DmaAck, PakClk, PakRead, PakWrite, PakCS, PakDOE, PakReset;
  logic [7:0]  CpuRData, DmaRData, PakDOut;
  logic [15:0] PakAddr;
  always #5 Clk = ~Clk;
  gbc_gamepak_sequencer #(.CLK_DIV(D), .RST_HOLD(H)) dut (
    .Clk(Clk), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuAck(CpuAck), .CpuRData(CpuRData),
    .DmaReq(DmaReq), .DmaAddr(DmaAddr), .DmaAck(DmaAck), .DmaRData(DmaRData),
    .PakClk(PakClk), .PakRead(PakRead), .PakWrite(PakWrite), .PakCS(PakCS),
    .PakAddr(PakAddr), .PakDOut(PakDOut), .PakDOE(PakDOE), .PakDIn(PakDIn),
    .PakReset(PakReset)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: a transaction is a numbered run of 3*D cycles (k = 1..3*D) after the accepting edge.
  int          hold = H, k = 0;
  bit          busy = 1'b0, m_dma = 1'b0, m_we = 1'b0, m_last_dma = 1'b1;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0, m_rdata = '0;
  logic        cw;
  assign cw = CpuReq && (!DmaReq || !RR || m_last_dma);
  always @(posedge Clk or posedge Reset)
    if (Reset) begin
      hold <= H; busy <= 1'b0; k <= 0; m_dma <= 1'b0; m_we <= 1'b0; m_last_dma <= 1'b1;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (hold > 0) hold <= hold - 1;
    else if (busy) begin
      if (k == 2 * D && !m_we) m_rdata <= PakDIn;
      if (k == 3 * D) busy <= 1'b0;
      else k <= k + 1;
    end else if (CpuReq || DmaReq) begin
      m_dma <= !cw;
      m_addr <= cw ? CpuAddr : DmaAddr;
      m_we <= cw && CpuWe;
      if (cw) m_wdata <= CpuWData;
      m_last_dma <= !cw;
      busy <= 1'b1;
      k <= 1;
    end
  always @(negedge Clk) begin
    bit strobe, ack;
    strobe = busy && k > D && k <= 2 * D;
    ack = busy && k == 3 * D;
    chk("pak_reset", PakReset, hold > 0);
    chk("pak_clk", PakClk, strobe);
    chk("pak_write", PakWrite, strobe && m_we);
    chk("pak_read", PakRead, busy && !m_we);
    chk("pak_doe", PakDOE, busy && m_we);
    chk("pak_cs", PakCS, busy && m_addr >= 16'hA000 && m_addr <= 16'hBFFF);
    chk("pak_addr", PakAddr, m_addr);
    chk("cpu_ack", CpuAck, ack && !m_dma);
    chk("dma_ack", DmaAck, ack && m_dma);
    if (busy && m_we) chk("pak_dout", PakDOut, m_wdata);
    if (ack && !m_we && !m_dma) chk("cpu_rdata", CpuRData, m_rdata);
    if (ack && m_dma) chk("dma_rdata", DmaRData, m_rdata);
  end
  task automatic xact(input bit dma, input bit we, input logic [15:0] a, input logic [7:0] wd,
                      input logic [7:0] din, output int ackj, output int nrd, output int nwr,
                      output int ncs, output int ndoe, output int fwr, output logic [7:0] rd,
                      output logic [7:0] dout);
    ackj = -1; nrd = 0; nwr = 0; ncs = 0; ndoe = 0; fwr = 0; rd = '0; dout = '0;
    @(negedge Clk);
    #1;
    PakDIn = din;
    if (dma) begin DmaReq = 1'b1; DmaAddr = a; end
    else begin CpuReq = 1'b1; CpuWe = we; CpuAddr = a; CpuWData = wd; end
    for (int j = 1; j <= 100 && ackj < 0; j++) begin
      @(negedge Clk);
      if (PakRead) nrd++;
      if (PakCS) ncs++;
      if (PakDOE) begin ndoe++; dout = PakDOut; end
      if (PakWrite) begin nwr++; if (fwr == 0) fwr = j; end
      if (dma ? DmaAck : CpuAck) begin ackj = j; rd = dma ? DmaRData : CpuRData; end
    end
    #1;
    CpuReq = 1'b0;
    DmaReq = 1'b0;
  endtask
  task automatic tie(input int ncpu, output int seq, output int jf, output int jl);
    int cl, dl;
    bit ca, da;
    cl = ncpu; dl = 1; seq = 0; jf = -1; jl = -1;
    @(negedge Clk);
    #1;
    CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h4000; DmaReq = 1'b1; DmaAddr = 16'h8000; PakDIn = 8'h77;
    for (int j = 1; j <= 200 && (cl + dl) > 0; j++) begin
      @(negedge Clk);
      ca = CpuAck; da = DmaAck;
      if (ca || da) begin seq = seq * 10 + (ca ? 1 : 2); if (jf < 0) jf = j; jl = j; end
      #1;
      if (ca) begin cl--; if (cl <= 0) CpuReq = 1'b0; else CpuAddr = CpuAddr + 16'd1; end
      if (da) begin dl--; DmaReq = 1'b0; end
    end
    CpuReq = 1'b0;
    DmaReq = 1'b0;
  endtask
  initial begin
    int rel, frd, fclk, nrd, ncs, ackj, nwr, ndoe, fwr, nack, seq, jf, jl;
    logic [7:0] rd, dout;
    #1 Reset = 1'b1;
    @(negedge Clk);
    chk("rst_pak_reset", PakReset, 1);
    chk("rst_read", PakRead, 0);
    chk("rst_addr", PakAddr, 0);
    chk("rst_cpu_ack", CpuAck, 0);
    @(negedge Clk);
    Reset = 1'b0; CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h0150; PakDIn = 8'hC3;
    rel = 0; frd = 0; fclk = 0; nrd = 0; ncs = 0; ackj = -1; rd = '0;
    for (int j = 1; j <= 60 && ackj < 0; j++) begin
      @(negedge Clk);
      if (PakReset === 1'b0 && rel == 0) rel = j;
      if (PakRead) begin nrd++; if (frd == 0) frd = j; end
      if (PakClk && fclk == 0) fclk = j;
      if (PakCS) ncs++;
      if (CpuAck) begin ackj = j; rd = CpuRData; end
    end
    #1 CpuReq = 1'b0;
    chk("hold_len", rel, 16);
    chk("rd_first_read", frd, 17);
    chk("rd_first_clk", fclk, 21);
    chk("rd_read_cycles", nrd, 12);
    chk("rd_cs_cycles", ncs, 0);
    chk("rd_ack_cycle", ackj, 28);
    chk("rd_data", rd, 8'hC3);
    xact(1'b0, 1'b1, 16'hA123, 8'h5A, 8'h00, ackj, nrd, nwr, ncs, ndoe, fwr, rd, dout);
    chk("wr_ack_cycle", ackj, 12);
    chk("wr_write_cycles", nwr, 4);
    chk("wr_first_write", fwr, 5);
    chk("wr_read_cycles", nrd, 0);
    chk("wr_cs_cycles", ncs, 12);
    chk("wr_doe_cycles", ndoe, 12);
    chk("wr_dout", dout, 8'h5A);
    @(negedge Clk);
    #1;
    DmaReq = 1'b1; DmaAddr = 16'h1234; PakDIn = 8'h99;
    fclk = 0;
    for (int j = 1; j <= 20 && fclk == 0; j++) begin
      @(negedge Clk);
      if (PakClk) fclk = j;
    end
    chk("abort_strobe_reached", fclk, 5);
    #2 Reset = 1'b1;
    #1;
    chk("abort_clk", PakClk, 0);
    chk("abort_read", PakRead, 0);
    chk("abort_pak_reset", PakReset, 1);
    DmaReq = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    nack = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge Clk);
      if (DmaAck) nack++;
    end
    chk("abort_no_ack", nack, 0);
    xact(1'b1, 1'b0, 16'h4321, 8'h00, 8'h3C, ackj, nrd, nwr, ncs, ndoe, fwr, rd, dout);
    chk("dma_ack_cycle", ackj, 12);
    chk("dma_rdata", rd, 8'h3C);
    chk("dma_read_cycles", nrd, 12);
    tie(1, seq, jf, jl);
    chk("tie1_order", seq, 12);
    chk("tie1_cpu_ack", jf, 12);
    chk("tie1_dma_ack", jl, 25);
    tie(2, seq, jf, jl);
    chk("tie2_order", seq, RR ? 121 : 112);
    chk("tie2_first", jf, 12);
    chk("tie2_last", jl, 38);
    for (int c = 0; c < 3000; c++) begin
      bit cack, dack;
      @(negedge Clk);
      #1;
      if (c == 1500) begin
        Reset = 1'b1; CpuReq = 1'b0; DmaReq = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        continue;
      end
      PakDIn = 8'($urandom);
      cack = busy && k == 3 * D && !m_dma;
      dack = busy && k == 3 * D && m_dma;
      if (!CpuReq || cack) begin
        if (CpuReq ? $urandom_range(0, 1) == 0 : $urandom_range(0, 3) == 0) begin
          CpuReq = 1'b1;
          CpuWe = 1'($urandom_range(0, 1));
          CpuAddr = $urandom_range(0, 1) ? (16'hA000 | 16'($urandom_range(0, 16'h1FFF))) : 16'($urandom);
          CpuWData = 8'($urandom);
        end else CpuReq = 1'b0;
      end
      if (!DmaReq || dack) begin
        if (DmaReq ? $urandom_range(0, 1) == 0 : $urandom_range(0, 3) == 0) begin
          DmaReq = 1'b1;
          DmaAddr = 16'($urandom);
        end else DmaReq = 1'b0;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
